// File: rtl/replica_pkg.sv
// Shared replica datapath types and sizing used by the ordering nodes.
package replica_pkg;

    localparam int city_div       = 16;
    localparam int city_div_log   = 4;
    localparam int replica_data_w = 32;

    typedef logic [replica_data_w-1:0] replica_data_t;

endpackage

// File: rtl/ordering_bank.sv
// One ordering buffer bank: single write port, registered read port, no reset.
module ordering_bank
    import replica_pkg::*;
#(
    parameter int DEPTH = city_div
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [city_div_log-1:0] wr_addr,
    input  replica_data_t           wr_data,
    input  logic                    rd_en,
    input  logic [city_div_log-1:0] rd_addr,
    output replica_data_t           rd_data
);

    replica_data_t mem [DEPTH];

    // Read data only moves when a read is issued, so it naturally holds between streams.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ordering_pingpong.sv
// Ping-pong ordering buffer: one bank collects upstream words while the other
// is streamed downstream as ordering_num+1 back-to-back beats.
module ordering_pingpong
    import replica_pkg::*;
#(
    parameter int DEPTH = city_div
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [city_div_log-1:0] ordering_num,
    input  logic                    in_valid,
    input  replica_data_t           in_data,
    input  logic                    shift_start,
    output logic                    out_valid,
    output replica_data_t           out_data,
    output logic                    busy,
    output logic [city_div_log:0]   wr_count,
    output logic                    overflow,
    output logic                    shift_err
);

    localparam int ADDR_W = city_div_log;
    localparam int CNT_W  = city_div_log + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic                wsel_reg, wsel_next;
    logic [CNT_W-1:0]    wr_count_reg, wr_count_next;
    logic [ADDR_W-1:0]   rptr_reg, rptr_next;
    logic [ADDR_W-1:0]   num_reg, num_next;
    logic                out_valid_reg, out_valid_next;
    logic                rd_bank_reg, rd_bank_next;
    replica_data_t       hold_reg, hold_next;
    logic                overflow_reg, overflow_next;
    logic                shift_err_reg, shift_err_next;

    logic                busy_int;
    logic                accept;
    logic                wr_fire;
    logic                rd_fire;
    replica_data_t       out_data_int;
    logic [1:0]          bank_wr_en;
    logic [1:0]          bank_rd_en;
    replica_data_t       bank_rd_data [2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            wsel_reg      <= 1'b0;
            wr_count_reg  <= '0;
            rptr_reg      <= '0;
            num_reg       <= '0;
            out_valid_reg <= 1'b0;
            rd_bank_reg   <= 1'b0;
            hold_reg      <= '0;
            overflow_reg  <= 1'b0;
            shift_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wsel_reg      <= wsel_next;
            wr_count_reg  <= wr_count_next;
            rptr_reg      <= rptr_next;
            num_reg       <= num_next;
            out_valid_reg <= out_valid_next;
            rd_bank_reg   <= rd_bank_next;
            hold_reg      <= hold_next;
            overflow_reg  <= overflow_next;
            shift_err_reg <= shift_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        wsel_next      = wsel_reg;
        wr_count_next  = wr_count_reg;
        rptr_next      = rptr_reg;
        num_next       = num_reg;
        rd_bank_next   = rd_bank_reg;
        hold_next      = hold_reg;

        // The final beat is still in flight after the FSM returns to IDLE.
        busy_int = (state_reg == SHIFT) || out_valid_reg;
        accept   = shift_start && !busy_int;
        wr_fire  = in_valid && (wr_count_reg < DEPTH_CNT);
        rd_fire  = (state_reg == SHIFT);

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = SHIFT;
                    wsel_next  = ~wsel_reg;
                    rptr_next  = '0;
                    num_next   = ordering_num;
                end
            end
            SHIFT: begin
                if (rptr_reg == num_reg) begin
                    state_next = IDLE;
                end else begin
                    rptr_next = rptr_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // A word arriving with the accepted shift lands in the bank being closed.
        if (accept) begin
            wr_count_next = '0;
        end else if (wr_fire) begin
            wr_count_next = wr_count_reg + 1'b1;
        end

        overflow_next  = overflow_reg  || (in_valid && !wr_fire);
        shift_err_next = shift_err_reg || (shift_start && busy_int);

        out_valid_next = rd_fire;
        if (rd_fire) begin
            rd_bank_next = ~wsel_reg;
        end

        out_data_int = out_valid_reg ? bank_rd_data[rd_bank_reg] : hold_reg;
        if (out_valid_reg) begin
            hold_next = out_data_int;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            assign bank_wr_en[gi] = wr_fire && (wsel_reg == 1'(gi));
            assign bank_rd_en[gi] = rd_fire && (wsel_reg != 1'(gi));

            ordering_bank #(
                .DEPTH (DEPTH)
            ) u_bank (
                .clk     (clk),
                .wr_en   (bank_wr_en[gi]),
                .wr_addr (wr_count_reg[ADDR_W-1:0]),
                .wr_data (in_data),
                .rd_en   (bank_rd_en[gi]),
                .rd_addr (rptr_reg),
                .rd_data (bank_rd_data[gi])
            );
        end
    endgenerate

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_int;
    assign busy      = busy_int;
    assign wr_count  = wr_count_reg;
    assign overflow  = overflow_reg;
    assign shift_err = shift_err_reg;

endmodule

// File: doc/ordering_pingpong.md
ORDERING_PINGPONG -- requirements
Module: ordering_pingpong

Interface
REQ-001 Parameter DEPTH, default city_div, words per bank.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 ordering_num  in  city_div_log  index of last valid word; a stream is ordering_num+1 words.
REQ-005 in_valid  in  1  upstream word strobe (from node_reg ordering_reg_valid or previous node out_valid).
REQ-006 in_data  in  replica_data_t  upstream word.
REQ-007 shift_start  in  1  one-cycle pulse (exchange_shift_d): close write bank, begin output of it.
REQ-008 out_valid  out  1  downstream word strobe (to next node or node_reg ordering_out_valid).
REQ-009 out_data  out  replica_data_t  downstream word.
REQ-010 busy  out  1  output stream in progress.
REQ-011 wr_count  out  city_div_log+1  words written into current write bank, saturating at DEPTH.
REQ-012 overflow  out  1  sticky: write attempted with write bank full.
REQ-013 shift_err  out  1  sticky: shift_start received while busy.

Function
REQ-014 Two banks of DEPTH words; wsel selects write bank, other bank is read bank.
REQ-015 in_valid with wr_count<DEPTH writes in_data at address wr_count of write bank and increments wr_count.
REQ-016 in_valid with wr_count==DEPTH discards word, sets overflow; wr_count holds.
REQ-017 States IDLE, SHIFT; IDLE->SHIFT on shift_start while IDLE; SHIFT->IDLE after read address ordering_num issued.
REQ-018 shift_start accepted at cycle T: wsel toggles, wr_count clears to 0 at end of T; an in_valid in cycle T writes into the bank being closed (at its wr_count), not the new one.
REQ-019 In SHIFT, read address rptr issues 0..ordering_num, one per cycle, starting cycle T+1.
REQ-020 Bank read is registered: out_valid high cycles T+2 .. T+2+ordering_num inclusive, out_data = word at rptr issued previous cycle; exactly ordering_num+1 beats, no gaps.
REQ-021 busy high from T+1 through last out_valid cycle inclusive.
REQ-022 Words at addresses >= closed bank's wr_count are emitted from stale contents; no masking, no error.
REQ-023 shift_start while busy: ignored (no toggle, no wr_count clear), shift_err set.
REQ-024 Input writes continue unthrottled during SHIFT into the new write bank.
REQ-025 ordering_num sampled at shift_start acceptance; changes during SHIFT do not affect current stream.
REQ-026 out_data holds last value when out_valid low.
REQ-027 Counters: rptr city_div_log bits, compare to latched ordering_num; wr_count city_div_log+1 bits, no wrap.

Reset
REQ-028 reset_n low asynchronously forces: state IDLE, wsel 0, wr_count 0, rptr 0, out_valid 0, out_data 0, busy 0, overflow 0, shift_err 0.
REQ-029 Reset mid-SHIFT aborts stream immediately; no further out_valid beats after release until next shift_start.
REQ-030 Bank memory contents are not reset.

Structure
REQ-031 replica_data_t, city_div, city_div_log taken from replica_pkg; no new package types.
REQ-032 One sub-module ordering_bank: DEPTH x replica_data_t, one write port, one registered read port, no reset; instantiated twice.

Verification (bench: city_div=16, ordering_num=5)
REQ-033 Write 6 words 0x11..0x16, shift_start at T -> out_valid T+2..T+7, data 0x11..0x16 in order, busy T+1..T+7.
REQ-034 in_valid 0xAA coincident with shift_start after 5 writes -> 0xAA emitted as 6th beat; wr_count=0 at T+1.
REQ-035 Stream 6 words 0x21..0x26 during SHIFT, second shift_start after idle -> outputs 0x21..0x26; first bank untouched.
REQ-036 shift_start at T+3 while busy -> shift_err=1, stream unaffected, wsel unchanged.
REQ-037 17 writes into one bank -> wr_count=16, overflow=1, word 17 not stored.
REQ-038 reset_n low at T+4 -> out_valid, busy 0 immediately; only beats T+2,T+3 observed.
